// File: rtl/impl_delay_checker.sv
// Fixed-delay implication monitor: every cycle with a & en starts an attempt that
// requires b high exactly DELAY edges later; reports pulses, counters and first failure.
module impl_delay_checker #(
    parameter int DELAY = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [5:0]       outstanding,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_start,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MON    = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DLY = CNT_W'(DELAY);

    logic [CNT_W-1:0] r_cyc;
    logic [DELAY-1:0] r_att;
    logic             r_pass_pulse;
    logic             r_fail_pulse;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [5:0]       r_outstanding;
    logic             r_ffv;
    logic [CNT_W-1:0] r_ffs;
    state_t           r_state;

    logic             w_start;
    logic             w_eval;
    logic             w_pass;
    logic             w_fail;
    logic [DELAY-1:0] w_att_next;
    logic [5:0]       w_pop;
    logic [CNT_W-1:0] w_ffs_val;
    state_t           w_state_next;

    assign w_start   = a & en;
    assign w_eval    = r_att[DELAY-1];
    assign w_pass    = w_eval & b;
    assign w_fail    = w_eval & ~b;
    // The attempt that fails now started DELAY edges ago.
    assign w_ffs_val = r_cyc - CNT_DLY;

    assign w_att_next[0] = w_start;
    genvar gi;
    generate
        for (gi = 1; gi < DELAY; gi++) begin : g_shift
            assign w_att_next[gi] = r_att[gi-1];
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DELAY; i++) begin
            w_pop = w_pop + 6'(w_att_next[i]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fail)
                    w_state_next = ST_FAILED;
                else if (en)
                    w_state_next = ST_MON;
            end
            ST_MON: begin
                if (w_fail)
                    w_state_next = ST_FAILED;
                else if (!en && (w_pop == 6'd0))
                    w_state_next = ST_IDLE;
            end
            ST_FAILED: begin
                if (clr)
                    w_state_next = en ? ST_MON : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc         <= '0;
            r_att         <= '0;
            r_pass_pulse  <= 1'b0;
            r_fail_pulse  <= 1'b0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_outstanding <= '0;
            r_ffv         <= 1'b0;
            r_ffs         <= '0;
            r_state       <= ST_IDLE;
        end else begin
            r_cyc         <= r_cyc + CNT_ONE;
            r_att         <= w_att_next;
            r_outstanding <= w_pop;
            r_pass_pulse  <= w_pass;
            r_fail_pulse  <= w_fail;
            r_state       <= w_state_next;
            // clr beats a same-edge event: it still pulses but is not counted.
            if (clr) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ffv      <= 1'b0;
                r_ffs      <= '0;
            end else begin
                if (w_pass && (r_pass_cnt != CNT_MAX))
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                if (w_fail && (r_fail_cnt != CNT_MAX))
                    r_fail_cnt <= r_fail_cnt + CNT_ONE;
                if (w_fail && !r_ffv) begin
                    r_ffv <= 1'b1;
                    r_ffs <= w_ffs_val;
                end
            end
        end
    end

    assign pass_pulse       = r_pass_pulse;
    assign fail_pulse       = r_fail_pulse;
    assign pass_cnt         = r_pass_cnt;
    assign fail_cnt         = r_fail_cnt;
    assign outstanding      = r_outstanding;
    assign first_fail_valid = r_ffv;
    assign first_fail_start = r_ffs;
    assign state            = r_state;

endmodule

// File: doc/impl_delay_checker.md
# impl_delay_checker

Synthesizable hardware monitor that checks the fixed-delay implication "a |-> b exactly DELAY cycles later" on every clock, with overlapping attempts. It consumes the same a/b stimulus stream that the simulation assertions check. It runs beside them on silicon or emulation, producing pass/fail pulses, saturating counters and a sticky first-failure record for the status block downstream. The default DELAY of 8 matches the seq_1 |-> ##4 (##4 b) check.

## Interface
- DELAY, 8, cycles from a sampled high to the required b sample; legal range 1..32
- CNT_W, 16, width of pass/fail counters and the cycle timestamp
- clk  in  1  sole clock; everything samples on posedge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  when 1, a may start new attempts; when 0, no new attempts start
- a  in  1  antecedent
- b  in  1  consequent
- clr  in  1  synchronous clear of counters and first-fail record
- pass_pulse  out  1  one-cycle pulse per passing attempt
- fail_pulse  out  1  one-cycle pulse per failing attempt
- pass_cnt  out  CNT_W  saturating pass count
- fail_cnt  out  CNT_W  saturating fail count
- outstanding  out  6  number of attempts in flight (0..DELAY)
- first_fail_valid  out  1  sticky; set on the first failure since reset or clr
- first_fail_start  out  CNT_W  cycle index at which the first failing attempt started
- state  out  2  0 IDLE, 1 MON, 2 FAILED

## Operation
- Reset (rst_n = 0 at a posedge): all outputs are 0, the attempt shift register is 0, the cycle counter is 0, and state is IDLE.
- Cycle counter cyc: increments on every non-reset edge and wraps modulo 2^CNT_W. It is unaffected by en and clr.
- Attempt register att[DELAY-1:0]: on each edge, att is shifted by one and bit 0 is loaded with (a & en).
- Evaluation: on the edge where att[DELAY-1] = 1, b is sampled on that same edge.
  - b = 1 gives a pass: pass_pulse is 1 for the next cycle.
  - b = 0 gives a fail: fail_pulse is 1 for the next cycle.
- Exactness: b must be high on precisely the DELAY-th edge after the start. b high at DELAY-1 or DELAY+1 does not count.
- Overlap: every cycle with a & en is an independent attempt. Back-to-back attempts are evaluated back-to-back.
- en = 0 does not flush attempts already in flight; they still evaluate and report.
- outstanding = popcount(att) after the edge.
- Counters: increment by 1 per event and saturate at 2^CNT_W - 1. They never wrap.
- First-fail record: on a fail while first_fail_valid = 0, it latches first_fail_start = (cyc - DELAY) mod 2^CNT_W and sets first_fail_valid. Later fails do not overwrite the record.
- clr = 1:
  - Zeroes pass_cnt, fail_cnt, first_fail_valid and first_fail_start.
  - An event evaluated on the same edge still pulses, but is not counted or recorded; clr wins.
  - att is not flushed.
- State machine, updated every edge:
  - IDLE -> MON when en = 1.
  - MON -> IDLE when en = 0 and outstanding would become 0.
  - MON or IDLE -> FAILED on any fail.
  - FAILED -> MON on clr with en = 1; FAILED -> IDLE on clr with en = 0.
  - rst_n = 0 -> IDLE from any state.
- Reset mid-operation discards all in-flight attempts. No pulse occurs for them, ever.

## Timing
- Latency: for a start sampled on edge k, the pulse is visible from edge k+DELAY+0 (registered) through edge k+DELAY+1. The counter reflects the event after edge k+DELAY.
- pass_pulse and fail_pulse are mutually exclusive and never high for 2 consecutive cycles from the same attempt.
- Maximum event rate is 1 per cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Steady pass: DELAY=8; en=1, a=1, b=1 from edge 0 for 20 edges. pass_pulse goes high after edge 8 and stays high. pass_cnt=12 after edge 19. fail_cnt=0, state=MON, outstanding=8.
- Single fail: a=1 on edge 3 only, b=0 throughout. fail_pulse occurs only after edge 11. fail_cnt=1, first_fail_valid=1, first_fail_start=3, state=FAILED. A second fail from a on edge 5 leaves first_fail_start=3.
- Exactness: a=1 on edge 2; b=1 on edges 9 and 11 only. Result is a fail after edge 10 and pass_cnt=0.
- Saturation: CNT_W=4; a=b=1 for 30 edges. pass_cnt holds at 15 and pass_pulse keeps pulsing.
- Reset mid-flight: a=1 on edges 0..4, b=1, rst_n=0 on edge 6 then released. There are no pulses afterwards, outstanding=0, and all counters are 0.
- clr collision: a pass is evaluated on the same edge as clr=1. The pass_pulse still fires, pass_cnt=0 afterwards, and a pass one edge later gives pass_cnt=1.
